// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control FSM driving the ALU control interface and datapath enables.
// Optional MC_CONTROL_BNE_EN adds a BNE state for opcode 000101 (otherwise it traps).
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUoperation,
  output logic       ALUsrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic       instr_done,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [3:0] S_BNE      = 4'd13;
  localparam logic [5:0] OP_BNE     = 6'h05;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(MEM_TIMEOUT - 1) : 16'd0;

  logic [3:0]  state, next_state;
  logic [5:0]  op_q, funct_q;
  logic [15:0] wait_cnt;
  logic        stalled, timed_out;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
           (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic logic [3:0] funct_to_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // wait_cnt holds the number of earlier stall cycles, so equality with
  // MEM_TIMEOUT-1 while stalled means this is the MEM_TIMEOUT-th stall cycle.
  assign stalled   = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;
  assign timed_out = TO_EN && stalled && (wait_cnt == TO_LAST);
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = funct_ok(funct) ? S_EXEC_R : S_TRAP;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_ADDI:      next_state = S_EXEC_I;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       next_state = S_BNE;
`endif
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_EXEC_R:   next_state = S_R_WB;
      S_EXEC_I:   next_state = S_I_WB;
      S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)      next_state = S_MEM_WB;
        else if (timed_out) next_state = S_FETCH;
      end
      S_MEM_WR:   if (mem_ready || timed_out) next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      op_q     <= 6'd0;
      funct_q  <= 6'd0;
      wait_cnt <= 16'd0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      wait_cnt <= (TO_EN && stalled && !timed_out) ? wait_cnt + 16'd1 : 16'd0;
    end
  end

  always_comb begin
    ALUoperation  = 4'b0000;
    ALUsrc        = 1'b0;
    IRWrite       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = 2'b00;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = !timed_out;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_EXEC_R: ALUoperation = funct_to_alu(funct_q);
        S_R_WB: begin
          ALUoperation = funct_to_alu(funct_q);
          RegWrite     = 1'b1;
          RegDst       = 1'b1;
          instr_done   = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ALUoperation = ALU_ADD;
          ALUsrc       = 1'b1;
        end
        S_I_WB: begin
          ALUoperation = ALU_ADD;
          ALUsrc       = 1'b1;
          RegWrite     = 1'b1;
          instr_done   = 1'b1;
        end
        S_MEM_RD: begin
          ALUoperation = ALU_ADD;
          ALUsrc       = 1'b1;
          IorD         = 1'b1;
          MemRead      = !timed_out;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          ALUoperation = ALU_ADD;
          ALUsrc       = 1'b1;
          IorD         = 1'b1;
          MemWrite     = !timed_out;
          instr_done   = mem_ready;
        end
        S_BRANCH: begin
          ALUoperation = ALU_SUB;
          PCSrc        = 2'b01;
          PCWrite      = zero;
          instr_done   = 1'b1;
        end
`ifdef MC_CONTROL_BNE_EN
        S_BNE: begin
          ALUoperation = ALU_SUB;
          PCSrc        = 2'b01;
          PCWrite      = !zero;
          instr_done   = 1'b1;
        end
`endif
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b10;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          illegal_instr = 1'b1;
          instr_done    = 1'b1;
        end
        default: ;
      endcase
      mem_timeout = timed_out;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: the driver pushes the expected output bundle per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [3:0] ALUoperation;
  logic       ALUsrc, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, PCWrite;
  logic [1:0] PCSrc;
  logic       illegal_instr, mem_timeout, instr_done;
  logic [3:0] state_dbg;

  mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALUoperation(ALUoperation), .ALUsrc(ALUsrc),
    .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .instr_done(instr_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Output bundle layout, LSB first: done, timeout, illegal, PCSrc[1:0], PCWrite,
  // MemtoReg, RegDst, RegWrite, MemWrite, MemRead, IorD, IRWrite, ALUsrc, ALUoperation[3:0].
  logic [17:0] act;
  assign act = {ALUoperation, ALUsrc, IRWrite, IorD, MemRead, MemWrite, RegWrite,
                RegDst, MemtoReg, PCWrite, PCSrc, illegal_instr, mem_timeout, instr_done};

  localparam logic [17:0] B_DONE = 18'd1 << 0;
  localparam logic [17:0] B_TMO  = 18'd1 << 1;
  localparam logic [17:0] B_ILL  = 18'd1 << 2;
  localparam logic [17:0] B_BR   = 18'd1 << 3;
  localparam logic [17:0] B_JMP  = 18'd1 << 4;
  localparam logic [17:0] B_PCW  = 18'd1 << 5;
  localparam logic [17:0] B_M2R  = 18'd1 << 6;
  localparam logic [17:0] B_RDST = 18'd1 << 7;
  localparam logic [17:0] B_RW   = 18'd1 << 8;
  localparam logic [17:0] B_MW   = 18'd1 << 9;
  localparam logic [17:0] B_MR   = 18'd1 << 10;
  localparam logic [17:0] B_IORD = 18'd1 << 11;
  localparam logic [17:0] B_IRW  = 18'd1 << 12;
  localparam logic [17:0] B_ASRC = 18'd1 << 13;

  function automatic logic [17:0] aop(input logic [3:0] a);
    return {a, 14'd0};
  endfunction

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  // One cycle: inputs change #1 after posedge; don't-care inputs are randomised
  // (z/rdy value 2 = random, opcode/funct random outside DECODE).
  task automatic step(input string nm, input logic rst_v, input bit dec,
                      input logic [5:0] op, input logic [5:0] fn,
                      input int z, input int rdy, input logic [17:0] e);
    reset     = rst_v;
    opcode    = dec ? op : 6'($urandom_range(0, 63));
    funct     = dec ? fn : 6'($urandom_range(0, 63));
    zero      = (z == 2) ? 1'($urandom_range(0, 1)) : z[0];
    mem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : rdy[0];
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string nm);
    step({nm, "_fetch"}, 1'b0, 1'b0, 6'd0, 6'd0, 2, 1, B_MR | B_IRW | B_PCW);
  endtask

  task automatic decode(input string nm, input logic [5:0] op, input logic [5:0] fn);
    step({nm, "_decode"}, 1'b0, 1'b1, op, fn, 2, 2, 18'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: outputs got %05h need %05h (state %0d)", nm, act, e, state_dbg);
      end
    end
  end

  logic [5:0] r_fn[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [3:0] r_alu[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step("reset0", 1'b1, 1'b0, 6'd0, 6'd0, 2, 2, 18'd0);
    step("reset1", 1'b1, 1'b0, 6'd0, 6'd0, 2, 2, 18'd0);

    // R-type sweep, 4 cycles each
    for (int i = 0; i < 5; i++) begin
      fetch_ok("rtype");
      decode("rtype", 6'h00, r_fn[i]);
      step("rtype_exec", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(r_alu[i]));
      step("rtype_wb", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(r_alu[i]) | B_RW | B_RDST | B_DONE);
    end

    // addi
    fetch_ok("addi");
    decode("addi", 6'h08, 6'd0);
    step("addi_exec", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(4'b0010) | B_ASRC);
    step("addi_wb", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(4'b0010) | B_ASRC | B_RW | B_DONE);

    // lw with two wait cycles in MEM_RD: 7 cycles total
    fetch_ok("lw");
    decode("lw", 6'h23, 6'd0);
    step("lw_addr", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(4'b0010) | B_ASRC);
    step("lw_rd_wait1", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, aop(4'b0010) | B_ASRC | B_MR | B_IORD);
    step("lw_rd_wait2", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, aop(4'b0010) | B_ASRC | B_MR | B_IORD);
    step("lw_rd_ready", 1'b0, 1'b0, 6'd0, 6'd0, 2, 1, aop(4'b0010) | B_ASRC | B_MR | B_IORD);
    step("lw_wb", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, B_RW | B_M2R | B_DONE);

    // sw, zero-wait
    fetch_ok("sw");
    decode("sw", 6'h2B, 6'd0);
    step("sw_addr", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(4'b0010) | B_ASRC);
    step("sw_wr", 1'b0, 1'b0, 6'd0, 6'd0, 2, 1, aop(4'b0010) | B_ASRC | B_MW | B_IORD | B_DONE);

    // beq taken / not taken
    fetch_ok("beq_t");
    decode("beq_t", 6'h04, 6'd0);
    step("beq_taken", 1'b0, 1'b0, 6'd0, 6'd0, 1, 2, aop(4'b0110) | B_BR | B_PCW | B_DONE);
    fetch_ok("beq_n");
    decode("beq_n", 6'h04, 6'd0);
    step("beq_not_taken", 1'b0, 1'b0, 6'd0, 6'd0, 0, 2, aop(4'b0110) | B_BR | B_DONE);

    // j
    fetch_ok("j");
    decode("j", 6'h02, 6'd0);
    step("j_jump", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, B_PCW | B_JMP | B_DONE);

    // illegal opcode and illegal funct
    fetch_ok("trap_op");
    decode("trap_op", 6'h3F, 6'd0);
    step("trap_op_pulse", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, B_ILL | B_DONE);
    fetch_ok("trap_fn");
    decode("trap_fn", 6'h00, 6'h03);
    step("trap_fn_pulse", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, B_ILL | B_DONE);

    // opcode 000101: BNE when enabled, trap otherwise
    fetch_ok("bne");
    decode("bne", 6'h05, 6'd0);
`ifdef MC_CONTROL_BNE_EN
    step("bne_taken", 1'b0, 1'b0, 6'd0, 6'd0, 0, 2, aop(4'b0110) | B_BR | B_PCW | B_DONE);
`else
    step("bne_trap", 1'b0, 1'b0, 6'd0, 6'd0, 0, 2, B_ILL | B_DONE);
`endif

    // reset during MEM_WR abandons the store
    fetch_ok("swrst");
    decode("swrst", 6'h2B, 6'd0);
    step("swrst_addr", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, aop(4'b0010) | B_ASRC);
    step("swrst_wait", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, aop(4'b0010) | B_ASRC | B_MW | B_IORD);
    step("swrst_reset0", 1'b1, 1'b0, 6'd0, 6'd0, 2, 1, 18'd0);
    step("swrst_reset1", 1'b1, 1'b0, 6'd0, 6'd0, 2, 1, 18'd0);
    step("swrst_release", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, B_MR);

    // FETCH stall: cycles 2..15 plain MemRead, 16th pulses mem_timeout, then restart
    for (int i = 2; i <= 15; i++)
      step("fetch_stall", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, B_MR);
    step("fetch_timeout", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, B_TMO);
    step("fetch_restart", 1'b0, 1'b0, 6'd0, 6'd0, 2, 0, B_MR);
    fetch_ok("post_to");
    decode("post_to", 6'h02, 6'd0);
    step("post_to_jump", 1'b0, 1'b0, 6'd0, 6'd0, 2, 2, B_PCW | B_JMP | B_DONE);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending entries got %0d need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
